// File: rtl/p4_router_egress_demux.sv
// p4_router_egress_demux: steers whole router packets to one of NUM_PORTS AXIS egress ports, or drops them.
// Optional saturating fwd/drop counters are built when P4_ROUTER_EGRESS_STATS_EN is defined.

module p4_router_egress_lane #(
  parameter int DW = 64,
  parameter int DB = 8
) (
  input  logic          en,
  input  logic [DW-1:0] s_data,
  input  logic [DB-1:0] s_keep,
  input  logic          s_last,
  input  logic          s_valid,
  output logic [DW-1:0] m_data,
  output logic [DB-1:0] m_keep,
  output logic          m_last,
  output logic          m_valid
);
  assign m_data  = s_data;
  assign m_keep  = s_keep;
  assign m_last  = s_last;
  assign m_valid = en & s_valid;
endmodule

module p4_router_egress_demux #(
  parameter int METADATA_WIDTH = 19,
  parameter int NUM_PORTS      = 4,
  parameter int DATA_BYTES     = 8,
  parameter int PORT_LSB       = 0,
  parameter int DROP_BIT       = 18,
  parameter int META_DEPTH     = 4
) (
  input  logic                             clk,
  input  logic                             aresetn,
  input  logic [8*DATA_BYTES-1:0]          s_axis_tdata,
  input  logic [DATA_BYTES-1:0]            s_axis_tkeep,
  input  logic                             s_axis_tlast,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [METADATA_WIDTH-1:0]        metadata_in,
  input  logic                             metadata_in_valid,
  output logic [NUM_PORTS*8*DATA_BYTES-1:0] m_axis_tdata,
  output logic [NUM_PORTS*DATA_BYTES-1:0]  m_axis_tkeep,
  output logic [NUM_PORTS-1:0]             m_axis_tlast,
  output logic [NUM_PORTS-1:0]             m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]             m_axis_tready,
  output logic [31:0]                      pkt_fwd_count,
  output logic [31:0]                      pkt_drop_count,
  output logic                             meta_overflow
);
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int FW     = PORT_W + 1;
  localparam int AW     = $clog2(META_DEPTH);
  localparam int DW     = 8 * DATA_BYTES;
  localparam logic [FW-1:0] NP = FW'(NUM_PORTS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_DISC = 2'd2;

  typedef struct packed {
    logic          drop;
    logic [FW-1:0] port;
  } meta_dec_t;

  function automatic meta_dec_t decode(input logic [METADATA_WIDTH-1:0] m);
    meta_dec_t d;
    d.drop = m[DROP_BIT];
    d.port = m[PORT_LSB +: FW];
    return d;
  endfunction

  // Only the decoded fields are queued; the rest of the metadata is don't-care here.
  logic unused_meta;
  assign unused_meta = ^metadata_in;

  meta_dec_t          meta_mem [META_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               empty, full, push, pop;
  logic [1:0]         state;
  logic [PORT_W-1:0]  sel_port;
  meta_dec_t          head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = s_axis_tvalid & s_axis_tready & s_axis_tlast;
  assign push  = metadata_in_valid & (~full | pop);
  // Bypass lets metadata arriving with the first beat be decoded in that same IDLE cycle.
  assign head  = empty ? decode(metadata_in) : meta_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) meta_mem[wr_ptr[AW-1:0]] <= decode(metadata_in);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      meta_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (metadata_in_valid && full && !pop) meta_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      sel_port <= '0;
    end else begin
      case (state)
        S_IDLE: if ((!empty || metadata_in_valid) && s_axis_tvalid) begin
          sel_port <= head.port[PORT_W-1:0];
          state    <= (head.drop || head.port >= NP) ? S_DISC : S_FWD;
        end
        S_FWD, S_DISC: if (pop) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      S_FWD:   s_axis_tready = m_axis_tready[sel_port];
      S_DISC:  s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    p4_router_egress_lane #(.DW(DW), .DB(DATA_BYTES)) u_lane (
      .en      (state == S_FWD && sel_port == PORT_W'(i)),
      .s_data  (s_axis_tdata),
      .s_keep  (s_axis_tkeep),
      .s_last  (s_axis_tlast),
      .s_valid (s_axis_tvalid),
      .m_data  (m_axis_tdata[i*DW +: DW]),
      .m_keep  (m_axis_tkeep[i*DATA_BYTES +: DATA_BYTES]),
      .m_last  (m_axis_tlast[i]),
      .m_valid (m_axis_tvalid[i])
    );
  end

`ifdef P4_ROUTER_EGRESS_STATS_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_fwd_count  <= '0;
      pkt_drop_count <= '0;
    end else if (pop) begin
      if (state == S_FWD && pkt_fwd_count != '1)   pkt_fwd_count  <= pkt_fwd_count + 1'b1;
      if (state == S_DISC && pkt_drop_count != '1) pkt_drop_count <= pkt_drop_count + 1'b1;
    end
  end
`else
  assign pkt_fwd_count  = '0;
  assign pkt_drop_count = '0;
`endif

endmodule

// File: tb/tb_p4_router_egress_demux.sv
// Directed bench for p4_router_egress_demux: routing, drop, stall, metadata overflow and mid-packet reset.
module tb_p4_router_egress_demux;
  logic          clk = 1'b0;
  logic          aresetn;
  logic [63:0]   s_tdata;
  logic [7:0]    s_tkeep;
  logic          s_tlast, s_tvalid, s_tready;
  logic [18:0]   meta;
  logic          meta_valid;
  logic [255:0]  m_tdata;
  logic [31:0]   m_tkeep;
  logic [3:0]    m_tlast, m_tvalid, m_tready;
  logic [31:0]   fwd_cnt, drop_cnt;
  logic          ovf;

  int checks = 0;
  int failures = 0;
  int acc [4] = '{0, 0, 0, 0};
  int stats;
  int exp_fwd = 0;
  int exp_drop = 0;

  always #5 clk = ~clk;

  p4_router_egress_demux dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .metadata_in(meta), .metadata_in_valid(meta_valid),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .pkt_fwd_count(fwd_cnt), .pkt_drop_count(drop_cnt), .meta_overflow(ovf)
  );

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (aresetn && m_tvalid[i] && m_tready[i]) acc[i] <= acc[i] + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_fwd_cnt"}, 64'(fwd_cnt), 64'(exp_fwd));
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
  endtask

  // Sends one packet (optionally with its metadata on the first beat) and checks every beat.
  task automatic pkt(input string tag, input logic [18:0] m, input bit with_meta,
                     input int nb, input int port, input logic [63:0] base);
    logic [3:0] ev;
    int snap;
    ev = '0;
    snap = 0;
    if (port >= 0) begin
      ev[port] = 1'b1;
      snap = acc[port];
    end
    meta = m; meta_valid = with_meta;
    s_tvalid = 1'b1; s_tdata = base; s_tkeep = 8'hFF; s_tlast = (nb == 1);
    #1;
    chk({tag, "_bubble_rdy"}, 64'(s_tready), 64'd0);
    chk({tag, "_bubble_vld"}, 64'(m_tvalid), 64'd0);
    step();
    meta_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      s_tdata = base + 64'(b);
      s_tlast = (b == nb - 1);
      s_tkeep = (b == nb - 1) ? 8'h0F : 8'hFF;
      #1;
      chk({tag, "_rdy"}, 64'(s_tready), 64'd1);
      chk({tag, "_vld"}, 64'(m_tvalid), 64'(ev));
      if (port >= 0) begin
        chk({tag, "_data"}, m_tdata[port*64 +: 64], base + 64'(b));
        chk({tag, "_last"}, 64'(m_tlast[port]), 64'(b == nb - 1));
        chk({tag, "_keep"}, 64'(m_tkeep[port*8 +: 8]), 64'(s_tkeep));
      end
      step();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1;
    chk({tag, "_idle_rdy"}, 64'(s_tready), 64'd0);
    if (port >= 0) begin
      exp_fwd += stats;
      chk({tag, "_beats"}, 64'(acc[port] - snap), 64'(nb));
    end else begin
      exp_drop += stats;
    end
    chk_counts(tag);
  endtask

  initial begin
`ifdef P4_ROUTER_EGRESS_STATS_EN
    stats = 1;
`else
    stats = 0;
`endif
    aresetn = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    meta = '0; meta_valid = 1'b0; m_tready = 4'hF;
    #1;
    chk("rst_rdy", 64'(s_tready), 64'd0);
    chk("rst_vld", 64'(m_tvalid), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk_counts("rst");
    step(); step();
    aresetn = 1'b1;
    step();

    // Forward, drop bit, out-of-range port field.
    pkt("p2", 19'd2, 1'b1, 3, 2, 64'hA000);
    chk("p2_p0_idle", 64'(acc[0] + acc[1] + acc[3]), 64'd0);
    pkt("drop", 19'h40001, 1'b1, 4, -1, 64'hB000);
    pkt("oor5", 19'd5, 1'b1, 2, -1, 64'hC000);

    // Port 1 with m_tready[1] pattern 1,0,0,1.
    begin
      int snap1;
      snap1 = acc[1];
      meta = 19'd1; meta_valid = 1'b1; s_tvalid = 1'b1; s_tdata = 64'hD0; s_tkeep = 8'hFF; s_tlast = 1'b0;
      #1; chk("stl_bubble", 64'(s_tready), 64'd0);
      step(); meta_valid = 1'b0;
      #1; chk("stl_b0_rdy", 64'(s_tready), 64'd1); chk("stl_b0_data", m_tdata[64 +: 64], 64'hD0);
      step(); s_tdata = 64'hD1; m_tready[1] = 1'b0;
      #1; chk("stl_c1_rdy", 64'(s_tready), 64'd0); chk("stl_c1_vld", 64'(m_tvalid), 64'd2);
      step();
      #1; chk("stl_c2_rdy", 64'(s_tready), 64'd0); chk("stl_c2_data", m_tdata[64 +: 64], 64'hD1);
      chk("stl_c2_vld", 64'(m_tvalid), 64'd2);
      step(); m_tready[1] = 1'b1;
      #1; chk("stl_c3_rdy", 64'(s_tready), 64'd1); chk("stl_c3_data", m_tdata[64 +: 64], 64'hD1);
      step(); s_tdata = 64'hD2;
      step(); s_tdata = 64'hD3; s_tlast = 1'b1;
      #1; chk("stl_last", 64'(m_tlast[1]), 64'd1);
      step(); s_tvalid = 1'b0; s_tlast = 1'b0;
      exp_fwd += stats;
      #1; chk("stl_beats", 64'(acc[1] - snap1), 64'd4);
      chk_counts("stl");
    end

    // Five metadata pulses into a depth-4 FIFO; the fifth (a drop) must be discarded.
    meta_valid = 1'b1;
    meta = 19'd3; step();
    meta = 19'd2; step();
    meta = 19'd1; step();
    meta = 19'd0; step();
    #1; chk("ovf_after4", 64'(ovf), 64'd0);
    meta = 19'h40000; step();
    meta_valid = 1'b0;
    #1; chk("ovf_after5", 64'(ovf), 64'd1);
    pkt("q3", 19'd0, 1'b0, 2, 3, 64'hE300);
    pkt("q2", 19'd0, 1'b0, 2, 2, 64'hE200);
    pkt("q1", 19'd0, 1'b0, 2, 1, 64'hE100);
    pkt("q0", 19'd0, 1'b0, 2, 0, 64'hE000);
    s_tvalid = 1'b1; s_tdata = 64'hF0;
    step(); step();
    #1; chk("held_rdy", 64'(s_tready), 64'd0); chk("held_vld", 64'(m_tvalid), 64'd0);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    s_tvalid = 1'b0;
    step();

    // Reset during beat 2 of 4, with a second entry queued behind it.
    meta = 19'd3; meta_valid = 1'b1; s_tvalid = 1'b1; s_tdata = 64'h90; s_tlast = 1'b0;
    step(); meta = 19'd0;
    #1; chk("mr_b0_vld", 64'(m_tvalid), 64'd8);
    step(); meta_valid = 1'b0; s_tdata = 64'h91;
    #1; chk("mr_b1_vld", 64'(m_tvalid), 64'd8);
    aresetn = 1'b0;
    #1;
    chk("mr_rst_vld", 64'(m_tvalid), 64'd0);
    chk("mr_rst_rdy", 64'(s_tready), 64'd0);
    chk("mr_rst_ovf", 64'(ovf), 64'd0);
    exp_fwd = 0; exp_drop = 0;
    chk_counts("mr_rst");
    step();
    aresetn = 1'b1;
    step(); step();
    #1; chk("mr_fifo_empty", 64'(s_tready), 64'd0);
    s_tvalid = 1'b0;
    step();
    pkt("post_rst", 19'd0, 1'b1, 2, 0, 64'h7700);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
